// File: rtl/biquad_pkg.sv
// biquad_pkg: shared types and helpers for the biquad cascade.
//   state_t      - sequencer states
//   K_B0..K_A2   - coefficient slot within a section (addr = stage*5 + k)
//   sat_w()      - clamp a signed value to a w-bit signed range
package biquad_pkg;

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_ACC, S_SAT, S_DONE} state_t;

  localparam int K_B0  = 0;
  localparam int K_B1  = 1;
  localparam int K_B2  = 2;
  localparam int K_A1  = 3;
  localparam int K_A2  = 4;
  localparam int NCOEF = 5;

  // Operates at 64 bits so one function serves every width up to 64.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/biquad_coef_bank.sv
// biquad_coef_bank: double-buffered coefficient store.
//   we/waddr/wdata - write one shadow coefficient (out-of-range addr ignored)
//   commit         - arm a shadow->active copy
//   accept         - frame accept; performs the armed copy
//   rd_st/rd_k     - combinational read of the active bank -> rd_coef
module biquad_coef_bank
  import biquad_pkg::*;
#(
  parameter int STAGES = 4,
  parameter int COEF_W = 16,
  parameter int FRAC   = 14,
  parameter int AW     = 5,
  parameter int SW     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic signed [COEF_W-1:0] wdata,
  input  logic                     commit,
  input  logic                     accept,
  input  logic [SW-1:0]            rd_st,
  input  logic [2:0]               rd_k,
  output logic signed [COEF_W-1:0] rd_coef
);

  localparam int N = STAGES * NCOEF;
  localparam logic signed [COEF_W-1:0] UNITY = COEF_W'(1 << FRAC);

  logic signed [COEF_W-1:0] shadow_q [N];
  logic signed [COEF_W-1:0] shadow_d [N];
  logic signed [COEF_W-1:0] active_q [N];
  logic signed [COEF_W-1:0] active_d [N];
  logic                     pending_q, pending_d;
  int                       widx, ridx;

  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    widx      = int'(waddr);
    if (we && widx < N) shadow_d[widx] = wdata;
    // The copy uses the pre-edge shadow, so a write on the accept edge lands next frame.
    if (accept && pending_q) active_d = shadow_q;
    if (accept) pending_d = 1'b0;
    // A commit on the accept edge re-arms for the following frame.
    if (commit) pending_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        shadow_q[i] <= (i % NCOEF == K_B0) ? UNITY : '0;
        active_q[i] <= (i % NCOEF == K_B0) ? UNITY : '0;
      end
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    ridx    = int'(rd_st) * NCOEF + int'(rd_k);
    rd_coef = (ridx < N) ? active_q[ridx] : '0;
  end

endmodule

// File: rtl/biquad_cascade.sv
// biquad_cascade: time-multiplexed multi-channel cascade of DF-I biquads,
// one shared multiplier and accumulator, 7 cycles per (channel, stage).
//   in_valid/in_ready/in_data    - frame in, CHANNELS samples packed by channel
//   out_valid/out_ready/out_data - frame out, held until accepted
//   coef_we/coef_addr/coef_wdata - shadow coefficient write (addr = stage*5+k)
//   coef_commit                  - shadow->active at next frame accept
module biquad_cascade
  import biquad_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int FRAC     = 14,
  parameter int STAGES   = 4,
  parameter int CHANNELS = 2,
  parameter int ACC_W    = 40,
  localparam int AW      = $clog2(STAGES * 5)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  input  logic                         coef_we,
  input  logic [AW-1:0]                coef_addr,
  input  logic [COEF_W-1:0]            coef_wdata,
  input  logic                         coef_commit
);

  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW = DATA_W + COEF_W;
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (FRAC - 1);

  state_t                      state_q, state_d;
  logic [CW-1:0]               ch_q, ch_d;
  logic [SW-1:0]               st_q, st_d;
  logic [2:0]                  k_q, k_d;
  logic [CHANNELS*DATA_W-1:0]  in_q, in_d, out_q, out_d;
  logic                        out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0]    stage_q, stage_d;     // previous stage output = next x0
  logic signed [ACC_W-1:0]     prod_q, prod_d, acc_q, acc_d;
  logic                        sub_q, sub_d;         // registered product is subtracted
  logic signed [DATA_W-1:0]    x1_q [CHANNELS][STAGES], x1_d [CHANNELS][STAGES];
  logic signed [DATA_W-1:0]    x2_q [CHANNELS][STAGES], x2_d [CHANNELS][STAGES];
  logic signed [DATA_W-1:0]    y1_q [CHANNELS][STAGES], y1_d [CHANNELS][STAGES];
  logic signed [DATA_W-1:0]    y2_q [CHANNELS][STAGES], y2_d [CHANNELS][STAGES];

  logic                        accept;
  logic signed [COEF_W-1:0]    coef;
  logic signed [DATA_W-1:0]    x0, op, sat_val;
  logic signed [PW-1:0]        mult;
  logic signed [ACC_W-1:0]     acc_fold, rnd, r;

  assign in_ready  = (state_q == S_IDLE);
  assign accept    = in_valid && (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_q;

  biquad_coef_bank #(
    .STAGES(STAGES), .COEF_W(COEF_W), .FRAC(FRAC), .AW(AW), .SW(SW)
  ) u_bank (
    .clk(clk), .rst(rst),
    .we(coef_we), .waddr(coef_addr), .wdata(coef_wdata),
    .commit(coef_commit), .accept(accept),
    .rd_st(st_q), .rd_k(k_q), .rd_coef(coef)
  );

  // Datapath: the only multiplier in the design.
  always_comb begin
    x0 = (st_q == '0) ? in_q[int'(ch_q)*DATA_W +: DATA_W] : stage_q;
    case (k_q)
      3'd0:    op = x0;
      3'd1:    op = x1_q[ch_q][st_q];
      3'd2:    op = x2_q[ch_q][st_q];
      3'd3:    op = y1_q[ch_q][st_q];
      3'd4:    op = y2_q[ch_q][st_q];
      default: op = '0;
    endcase
    mult     = coef * op;
    acc_fold = sub_q ? (acc_q - prod_q) : (acc_q + prod_q);
    rnd      = acc_q + RND;
    r        = rnd >>> FRAC;
    sat_val  = DATA_W'(sat_w({{(64-ACC_W){r[ACC_W-1]}}, r}, DATA_W));
  end

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    st_d        = st_q;
    k_d         = k_q;
    in_d        = in_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    stage_d     = stage_q;
    prod_d      = prod_q;
    sub_d       = sub_q;
    acc_d       = acc_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    y1_d        = y1_q;
    y2_d        = y2_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        in_d    = in_data;
        ch_d    = '0;
        st_d    = '0;
        k_d     = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        prod_d = {{(ACC_W-PW){mult[PW-1]}}, mult};
        sub_d  = (k_q >= 3'd3);
        // Product of the previous cycle folds in one cycle late; k=0 starts a fresh sum.
        acc_d  = (k_q == 3'd0) ? '0 : acc_fold;
        if (k_q == 3'd4) begin
          k_d     = '0;
          state_d = S_ACC;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      S_ACC: begin
        acc_d   = acc_fold;
        state_d = S_SAT;
      end
      S_SAT: begin
        x2_d[ch_q][st_q] = x1_q[ch_q][st_q];
        x1_d[ch_q][st_q] = x0;
        y2_d[ch_q][st_q] = y1_q[ch_q][st_q];
        y1_d[ch_q][st_q] = sat_val;
        stage_d          = sat_val;
        state_d          = S_MAC;
        if (st_q == SW'(STAGES - 1)) begin
          out_d[int'(ch_q)*DATA_W +: DATA_W] = sat_val;
          st_d = '0;
          if (ch_q == CW'(CHANNELS - 1)) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
          end else begin
            ch_d = ch_q + CW'(1);
          end
        end else begin
          st_d = st_q + SW'(1);
        end
      end
      S_DONE: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      st_q        <= '0;
      k_q         <= '0;
      in_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      stage_q     <= '0;
      prod_q      <= '0;
      sub_q       <= 1'b0;
      acc_q       <= '0;
      for (int c = 0; c < CHANNELS; c++)
        for (int s = 0; s < STAGES; s++) begin
          x1_q[c][s] <= '0;
          x2_q[c][s] <= '0;
          y1_q[c][s] <= '0;
          y2_q[c][s] <= '0;
        end
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      st_q        <= st_d;
      k_q         <= k_d;
      in_q        <= in_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      stage_q     <= stage_d;
      prod_q      <= prod_d;
      sub_q       <= sub_d;
      acc_q       <= acc_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
    end
  end

endmodule

// File: tb/tb_biquad_cascade.sv
// tb_biquad_cascade: directed vectors with hand-computed expectations for
// biquad_cascade at default parameters (16-bit, Q2.14, 4 stages, 2 channels).
module tb_biquad_cascade;

  localparam int DW = 16;
  localparam int CH = 2;
  localparam int ST = 4;
  localparam int AW = $clog2(ST * 5);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CH*DW-1:0]  in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [CH*DW-1:0]  out_data;
  logic              coef_we = 1'b0;
  logic [AW-1:0]     coef_addr = '0;
  logic [15:0]       coef_wdata = '0;
  logic              coef_commit = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  biquad_cascade dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_commit(coef_commit)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // All tasks start and end #1 after a rising edge.
  task automatic wr(input int addr, input int val);
    coef_we    = 1'b1;
    coef_addr  = AW'(addr);
    coef_wdata = 16'(val);
    @(posedge clk); #1;
    coef_we    = 1'b0;
  endtask

  task automatic commit();
    coef_commit = 1'b1;
    @(posedge clk); #1;
    coef_commit = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Runs one frame; 'mid' writes stage0 B0=0 plus commit 10 cycles in.
  task automatic frame(input int a0, input int a1, input bit mid,
                       output logic signed [15:0] o0, output logic signed [15:0] o1,
                       output int lat);
    chk("in_ready_idle", longint'(in_ready), 1);
    in_data  = {16'(a1), 16'(a0)};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("in_ready_busy", longint'(in_ready), 0);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      coef_we     = 1'b0;
      coef_commit = 1'b0;
      lat++;
      if (mid && lat == 10) begin
        coef_we     = 1'b1;
        coef_addr   = '0;
        coef_wdata  = '0;
        coef_commit = 1'b1;
      end
    end
    if (!out_valid) chk("timeout", 0, 1);
    o0 = out_data[15:0];
    o1 = out_data[31:16];
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  logic signed [15:0] o0, o1;
  int                 lat;
  logic [31:0]        held;

  initial begin
    #1;
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", longint'(out_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Default coefficients are unity passthrough; latency 7*4*2.
    frame(1000, -1234, 1'b0, o0, o1, lat);
    chk("pass_ch0", o0, 1000);
    chk("pass_ch1", o1, -1234);
    chk("latency", lat, 56);

    // Stage0 gain 0.5: 1.5 -> 2, -1.5 -> -1, 2.5 -> 3, -2.5 -> -2 (round half up).
    wr(0, 8192);
    commit();
    frame(3, -3, 1'b0, o0, o1, lat);
    chk("rnd_pos3", o0, 2);
    chk("rnd_neg3", o1, -1);
    frame(5, -5, 1'b0, o0, o1, lat);
    chk("rnd_pos5", o0, 3);
    chk("rnd_neg5", o1, -2);

    // Near-2x gain saturates both ways.
    wr(0, 32767);
    commit();
    frame(30000, -30000, 1'b0, o0, o1, lat);
    chk("sat_hi", o0, 32767);
    chk("sat_lo", o1, -32768);

    // Pole at 0.5 in stage0: impulse decays by halves.
    do_reset();
    wr(3, -8192);
    commit();
    frame(16384, 0, 1'b0, o0, o1, lat);
    chk("iir0_ch0", o0, 16384);
    chk("iir0_ch1", o1, 0);
    frame(0, 0, 1'b0, o0, o1, lat);
    chk("iir1_ch0", o0, 8192);
    chk("iir1_ch1", o1, 0);
    frame(0, 0, 1'b0, o0, o1, lat);
    chk("iir2_ch0", o0, 4096);
    frame(0, 0, 1'b0, o0, o1, lat);
    chk("iir3_ch0", o0, 2048);
    chk("iir3_ch1", o1, 0);

    // Shadow write without commit; then mid-frame commit only affects next frame.
    do_reset();
    wr(0, 0);
    frame(500, -700, 1'b0, o0, o1, lat);
    chk("nocommit_ch0", o0, 500);
    chk("nocommit_ch1", o1, -700);
    frame(500, -700, 1'b1, o0, o1, lat);
    chk("midcommit_ch0", o0, 500);
    chk("midcommit_ch1", o1, -700);
    frame(500, -700, 1'b0, o0, o1, lat);
    chk("after_commit_ch0", o0, 0);
    chk("after_commit_ch1", o1, 0);

    // Backpressure: result holds while out_ready is low.
    do_reset();
    out_ready = 1'b0;
    frame(111, -222, 1'b0, o0, o1, lat);
    held = {16'(-222), 16'(111)};
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", longint'(out_valid), 1);
      chk("bp_data", longint'(out_data), longint'(held));
      chk("bp_in_ready", longint'(in_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", longint'(in_ready), 1);
    chk("bp_release_valid", longint'(out_valid), 0);

    // Reset mid-frame with a non-unity bank active; everything returns to defaults.
    wr(0, 0);
    commit();
    in_data  = {16'(-5), 16'(5)};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_in_ready", longint'(in_ready), 1);
    chk("abort_out_valid", longint'(out_valid), 0);
    chk("abort_out_data", longint'(out_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    frame(77, -88, 1'b0, o0, o1, lat);
    chk("post_abort_ch0", o0, 77);
    chk("post_abort_ch1", o1, -88);
    chk("post_abort_lat", lat, 56);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/biquad_cascade.md
# biquad_cascade

Time-multiplexed, multi-channel cascade of Direct Form I biquad sections sharing one multiplier and one accumulator. Each accepted frame carries one sample per channel; every sample passes through STAGES sections in order, with per-channel, per-stage history. Coefficients are runtime-loadable through a double-buffered register bank, so filter changes never land mid-frame. Sits between the PCM source and the output mixer, replacing single-section filtering.

## Interface
- DATA_W, 16: sample width, signed.
- COEF_W, 16: coefficient width, signed, fixed point with FRAC fractional bits.
- FRAC, 14: coefficient fractional bits; 1<<FRAC is unity.
- STAGES, 4: cascaded sections per channel, 1..8.
- CHANNELS, 2: independent channels, 1..8.
- ACC_W, 40: accumulator width; must be at least DATA_W+COEF_W+3.

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  frame present.
- in_ready  out  1  high only in IDLE.
- in_data  in  CHANNELS*DATA_W  channel c in bits [c*DATA_W +: DATA_W].
- out_valid  out  1  result frame valid; held until out_ready.
- out_ready  in  1  downstream accepts.
- out_data  out  CHANNELS*DATA_W  same packing as in_data.
- coef_we  in  1  write one shadow coefficient.
- coef_addr  in  $clog2(STAGES*5)  stage*5+k, with k = 0 B0, 1 B1, 2 B2, 3 A1, 4 A2.
- coef_wdata  in  COEF_W  coefficient value.
- coef_commit  in  1  pulse; shadow bank is copied to the active bank at the next frame accept.

## Operation
- Per section: y = B0·x0 + B1·x1 + B2·x2 − A1·y1 − A2·y2. A0 is implicitly 1 and is not stored.
- States: IDLE, MAC, ACC, SAT, DONE.
  - IDLE: on in_valid && in_ready, latch in_data. If a commit is pending, copy shadow to active and clear pending. Set ch=0, st=0, k=0, then go to MAC.
  - MAC (k=0..4): register product coef[st][k]·operand[k]. Operands are x0 (stage input), x1, x2, y1, y2. Accumulate the previous cycle's product; k=0 loads the accumulator instead of adding. k=3 and k=4 subtract. Products are sign-extended to ACC_W.
  - ACC: fold in the final product.
  - SAT: compute r = (acc + (1<<(FRAC-1))) >>> FRAC, i.e. round half up. Saturate r to [−2^(DATA_W−1), 2^(DATA_W−1)−1]. Shift history for (ch,st): x2←x1, x1←x0, y2←y1, y1←sat. The saturated value becomes the next stage's x0. After the last stage, write it to out_data[ch]. Advance st, then ch. After the final (ch,st), go to DONE.
  - DONE: out_valid=1 and out_data stable; on out_ready go to IDLE.
- History is stored at DATA_W, per channel and per stage; y1 and y2 hold saturated outputs.
- coef_we writes the shadow bank in any state; an out-of-range coef_addr is ignored.
- coef_commit in any state sets pending. A coef_commit on the accept edge takes effect at the following frame.
- Reset values:
  - State IDLE, in_ready=1, out_valid=0, out_data=0.
  - All history 0, commit pending 0.
  - Both banks: B0=1<<FRAC, all other coefficients 0, giving unity passthrough.
- rst mid-frame aborts the frame and returns everything to reset values, coefficients included.

## Timing
- 7 cycles per (channel, stage): 5 MAC, 1 ACC, 1 SAT.
- out_valid rises exactly 7·STAGES·CHANNELS edges after the accepting edge (56 for defaults).
- in_ready stays low from the accepting edge until the edge after the out_valid && out_ready handshake. Minimum frame period is 7·S·C+2 cycles when out_ready is tied high.
- No combinational path from in_valid or out_ready to any output except in_ready, which is decoded from state only.

## Structure
- Package biquad_pkg:
  - state enum;
  - coefficient index constants K_B0..K_A2;
  - a saturate function parameterised by width.
- Sub-module biquad_coef_bank: shadow and active registers, write port, commit-pending flag, copy on frame accept, combinational read by (st,k).
- Single multiplier in the top level. Multiplier count must not scale with STAGES or CHANNELS.

## Test plan
- Reset defaults, in_data={ch1=−1234, ch0=1000} → out_data identical; out_valid exactly 56 cycles after accept.
- STAGES=1, B0=8192, others 0; inputs 3 and −3 → outputs 2 and −1, confirming round half up.
- B0=32767, input 30000 → 32767; input −30000 → −32768.
- Impulse 16384 then zeros, stage 0 A1=−8192 (pole 0.5), other stages passthrough → ch0 outputs 16384, 8192, 4096, 2048; ch1 remains 0.
- Write B0=0 with a commit mid-frame → current frame unchanged, next frame outputs 0. A write without commit has no effect.
- out_ready held low 10 cycles → out_valid and out_data stable, in_ready low. rst asserted at MAC cycle 20 → all outputs at reset values, and the next frame is passthrough.
